// File: rtl/alu_exec_stage.sv
// Execute-stage sequencer for the multicycle MIPS ALU: decodes ALUCtrl, holds operands one EXEC cycle,
// captures ALUOut/Zero and hands the result downstream. Optional op counter: define ALU_EXEC_PERF_EN.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_illegal
`ifdef ALU_EXEC_PERF_EN
  ,
  output logic [31:0]      op_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [2:0] C_ADD = 3'b000;
  localparam logic [2:0] C_SUB = 3'b001;
  localparam logic [2:0] C_SLT = 3'b010;
  localparam logic [2:0] C_SRL = 3'b011;
  localparam logic [2:0] C_SLL = 3'b100;
  localparam logic [2:0] C_OR  = 3'b101;
  localparam logic [2:0] C_AND = 3'b110;
  localparam logic [2:0] C_NOR = 3'b111;

  // Returns {illegal, ctrl}; unknown R-type functs fall back to add and are flagged.
  function automatic logic [3:0] decode_ctrl(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] d;
    d = {1'b0, C_ADD};
    case (op)
      2'b00: d = {1'b0, C_ADD};
      2'b01: d = {1'b0, C_SUB};
      2'b11: d = {1'b0, C_OR};
      default: begin
        case (fn)
          6'b100000: d = {1'b0, C_ADD};
          6'b100010: d = {1'b0, C_SUB};
          6'b101010: d = {1'b0, C_SLT};
          6'b000010: d = {1'b0, C_SRL};
          6'b000000: d = {1'b0, C_SLL};
          6'b100101: d = {1'b0, C_OR};
          6'b100100: d = {1'b0, C_AND};
          6'b100111: d = {1'b0, C_NOR};
          default:   d = {1'b1, C_ADD};
        endcase
      end
    endcase
    return d;
  endfunction

  logic [1:0]       state;
  logic [2:0]       dec_ctrl;
  logic             dec_illegal;
  logic             is_shift;
  logic             accept;
  logic             vld_p1;
  logic [2:0]       ctrl_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             illegal_p0;
  logic [WIDTH-1:0] data_p1;
  logic             zero_p1;
  logic             illegal_p1;

  assign {dec_illegal, dec_ctrl} = decode_ctrl(alu_op, funct);
  assign is_shift = (dec_ctrl == C_SRL) || (dec_ctrl == C_SLL);

  // A flush cycle never accepts an op, whatever state the stage is in.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_IDLE:  in_ready = 1'b1;
      S_DONE:  in_ready = res_ready;
      default: in_ready = 1'b0;
    endcase
    in_ready = in_ready & ~flush;
  end

  assign accept = in_valid & in_ready;
  assign vld_p1 = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ctrl_p0    <= C_ADD;
      a_p0       <= '0;
      b_p0       <= '0;
      illegal_p0 <= 1'b0;
      data_p1    <= '0;
      zero_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE:  if (in_valid) state <= S_EXEC;
          S_EXEC:  state <= S_DONE;
          S_DONE:  if (res_ready) state <= in_valid ? S_EXEC : S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
      // Stage p0: operand/control latch feeding the ALU
      if (accept) begin
        ctrl_p0    <= dec_ctrl;
        a_p0       <= is_shift ? {{(WIDTH-5){1'b0}}, shamt} : opa;
        b_p0       <= opb;
        illegal_p0 <= dec_illegal;
      end
      // Stage p1: ALUOut capture at the end of EXEC
      if (state == S_EXEC && !flush) begin
        data_p1    <= alu_out;
        zero_p1    <= alu_zero;
        illegal_p1 <= illegal_p0;
      end
    end
  end

  assign alu_ctrl    = ctrl_p0;
  assign alu_a       = a_p0;
  assign alu_b       = b_p0;
  assign res_valid   = vld_p1;
  assign res_data    = data_p1;
  assign res_zero    = zero_p1;
  assign res_illegal = illegal_p1;

`ifdef ALU_EXEC_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (vld_p1 && res_ready && !flush) begin
      op_count <= op_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: behavioural ALU model, scoreboard of expected results,
// per-scenario tasks. Define ALU_EXEC_PERF_EN to also check op_count.
module tb_alu_exec_stage;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, in_valid, in_ready, alu_zero, res_valid, res_ready, res_zero, res_illegal;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic [2:0] alu_ctrl;
  logic [W-1:0] opa, opb, alu_a, alu_b, alu_out, res_data;
`ifdef ALU_EXEC_PERF_EN
  logic [31:0] op_count;
`endif

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .shamt(shamt), .opa(opa), .opb(opb),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
    .res_illegal(res_illegal)
`ifdef ALU_EXEC_PERF_EN
    , .op_count(op_count)
`endif
  );

  // External ALU
  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a - alu_b;
      3'b010: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      3'b011: alu_out = alu_b >> alu_a[4:0];
      3'b100: alu_out = alu_b << alu_a[4:0];
      3'b101: alu_out = alu_a | alu_b;
      3'b110: alu_out = alu_a & alu_b;
      default: alu_out = ~(alu_a | alu_b);
    endcase
    alu_zero = (alu_out == '0);
  end

  typedef struct packed {
    logic illegal;
    logic zero;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int hs_cyc[$];
  int assertions = 0;
  int failures = 0;
  int cyc = 0;
  logic [W-1:0] last_data = '0;
  logic [31:0] exp_count = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.illegal = 1'b0;
    e.data = a + b;
    case (op)
      2'b01: e.data = a - b;
      2'b11: e.data = a | b;
      2'b10: begin
        case (fn)
          6'h20: e.data = a + b;
          6'h22: e.data = a - b;
          6'h2a: e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h02: e.data = b >> sh;
          6'h00: e.data = b << sh;
          6'h25: e.data = a | b;
          6'h24: e.data = a & b;
          6'h27: e.data = ~(a | b);
          default: begin e.data = a + b; e.illegal = 1'b1; end
        endcase
      end
      default: e.data = a + b;
    endcase
    e.zero = (e.data == '0);
    return e;
  endfunction

  // Scoreboard sink: every downstream handshake must match the oldest pending op.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid && res_ready && !flush) begin
      assertions++;
      exp_count <= exp_count + 1;
      hs_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got data=%h zero=%b with no op pending", res_data, res_zero);
      end else begin
        e = sb.pop_front();
        last_data = e.data;
        if ({res_illegal, res_zero, res_data} !== {e.illegal, e.zero, e.data}) begin
          failures++;
          $display("FAIL result: got ill=%b zero=%b data=%h, expected ill=%b zero=%b data=%h",
                   res_illegal, res_zero, res_data, e.illegal, e.zero, e.data);
        end
      end
    end
  end

  task automatic drive_op(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_res);
    int n = 0;
    bit acc = 1'b0;
    alu_op = op; funct = fn; shamt = sh; opa = a; opb = b; in_valid = 1'b1;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && expect_res) sb.push_back(model(op, fn, sh, a, b));
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    assertions++;
    if (!acc) begin failures++; $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n); end
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    alu_op = '0; funct = '0; shamt = '0; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    assertions++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
    assertions++; if (res_data !== '0) begin failures++; $display("FAIL rst_res_data: got %h expected 0", res_data); end
    assertions++; if ({res_zero, res_illegal} !== 2'b00) begin failures++; $display("FAIL rst_flags: got %b expected 00", {res_zero, res_illegal}); end
    assertions++; if ({alu_ctrl, alu_a, alu_b} !== '0) begin failures++; $display("FAIL rst_latch: got ctrl=%b a=%h b=%h expected 0", alu_ctrl, alu_a, alu_b); end
    rst_n = 1'b1;
    @(negedge clk);
    assertions++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
`ifdef ALU_EXEC_PERF_EN
    assertions++; if (op_count !== 32'd0) begin failures++; $display("FAIL rst_op_count: got %0d expected 0", op_count); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    res_ready = 1'b1;
    drive_op(2'b00, 6'h00, 5'd0, 32'd5, 32'd7, 1'b1);
    @(negedge clk);
    assertions++; if ({res_valid, in_ready} !== 2'b00) begin failures++; $display("FAIL add_exec_hs: got valid=%b ready=%b expected 0 0", res_valid, in_ready); end
    assertions++; if ({alu_ctrl, alu_a, alu_b} !== {3'b000, 32'd5, 32'd7}) begin failures++; $display("FAIL add_latch: got ctrl=%b a=%h b=%h expected 000 5 7", alu_ctrl, alu_a, alu_b); end
    @(negedge clk);
    assertions++; if ({res_valid, res_zero, res_data} !== {2'b10, 32'd12}) begin failures++; $display("FAIL add_latency: got valid=%b zero=%b data=%h expected 1 0 c", res_valid, res_zero, res_data); end
    drain();
  endtask

  task automatic test_beq_hold();
    res_ready = 1'b0;
    drive_op(2'b01, 6'h00, 5'd0, 32'h1234, 32'h1234, 1'b1);
    @(negedge clk);
    assertions++; if (alu_ctrl !== 3'b001) begin failures++; $display("FAIL beq_ctrl: got %b expected 001", alu_ctrl); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      assertions++;
      if ({res_valid, res_zero, in_ready, res_data} !== {3'b110, 32'd0}) begin
        failures++;
        $display("FAIL beq_hold[%0d]: got valid=%b zero=%b in_ready=%b data=%h expected 1 1 0 0", i, res_valid, res_zero, in_ready, res_data);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    drain();
  endtask

  task automatic test_decode();
    logic [5:0] fns [8] = '{6'h20, 6'h22, 6'h2a, 6'h02, 6'h00, 6'h25, 6'h24, 6'h27};
    res_ready = 1'b1;
    drive_op(2'b10, 6'h00, 5'd4, 32'hFFFF_0000, 32'h1, 1'b1);
    @(negedge clk);
    assertions++; if ({alu_ctrl, alu_a, alu_b} !== {3'b100, 32'd4, 32'd1}) begin failures++; $display("FAIL sll_latch: got ctrl=%b a=%h b=%h expected 100 4 1", alu_ctrl, alu_a, alu_b); end
    @(negedge clk);
    assertions++; if (res_data !== 32'h10) begin failures++; $display("FAIL sll_data: got %h expected 10", res_data); end
    drain();
    drive_op(2'b10, 6'h3f, 5'd0, 32'd3, 32'd4, 1'b1);
    @(negedge clk);
    assertions++; if (alu_ctrl !== 3'b000) begin failures++; $display("FAIL illegal_ctrl: got %b expected 000", alu_ctrl); end
    @(negedge clk);
    assertions++; if (res_illegal !== 1'b1) begin failures++; $display("FAIL illegal_flag: got %b expected 1", res_illegal); end
    drain();
    for (int i = 0; i < 8; i++)
      drive_op(2'b10, fns[i], 5'($urandom_range(0, 31)), $urandom, $urandom, 1'b1);
    drive_op(2'b10, 6'h02, 5'd31, 32'd0, 32'h8000_0000, 1'b1);
    drive_op(2'b10, 6'h2a, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    drive_op(2'b10, 6'h2a, 5'd0, 32'd1, 32'hFFFF_FFFF, 1'b1);
    drive_op(2'b00, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    drive_op(2'b01, 6'h00, 5'd0, 32'd0, 32'd1, 1'b1);
    drive_op(2'b11, 6'h2a, 5'd3, 32'h0F0F_0000, 32'h0000_00F0, 1'b1);
    drive_op(2'b10, 6'h27, 5'd0, 32'h0, 32'h0, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] cnt0;
    res_ready = 1'b1;
    hs_cyc.delete();
    cnt0 = exp_count;
    for (int i = 0; i < 6; i++)
      drive_op(2'b00, 6'h00, 5'd0, 32'(i * 3), 32'd100, 1'b1);
    drain();
    assertions++; if (hs_cyc.size() !== 6) begin failures++; $display("FAIL b2b_count: got %0d results expected 6", hs_cyc.size()); end
    for (int i = 1; i < hs_cyc.size(); i++) begin
      assertions++;
      if (hs_cyc[i] - hs_cyc[i-1] !== 2) begin failures++; $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 2", i, hs_cyc[i] - hs_cyc[i-1]); end
    end
`ifdef ALU_EXEC_PERF_EN
    assertions++; if (op_count !== cnt0 + 32'd6) begin failures++; $display("FAIL b2b_op_count: got %0d expected %0d", op_count, cnt0 + 32'd6); end
`endif
  endtask

  task automatic test_flush();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; exp_count = '0; last_data = '0;
    res_ready = 1'b1;
    drive_op(2'b00, 6'h00, 5'd0, 32'd10, 32'd20, 1'b1);
    drive_op(2'b01, 6'h00, 5'd0, 32'd50, 32'd8, 1'b1);
    drain();
    // Squash in EXEC
    drive_op(2'b00, 6'h00, 5'd0, 32'd1, 32'd2, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    assertions++; if ({res_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL flush_exec_idle: got valid=%b ready=%b expected 0 1", res_valid, in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      assertions++; if (res_valid !== 1'b0) begin failures++; $display("FAIL flush_exec_novalid[%0d]: got %b expected 0", i, res_valid); end
    end
    assertions++; if (res_data !== 32'd42) begin failures++; $display("FAIL flush_keep_data: got %h expected 2a", res_data); end
`ifdef ALU_EXEC_PERF_EN
    assertions++; if (op_count !== 32'd2) begin failures++; $display("FAIL flush_op_count: got %0d expected 2", op_count); end
`endif
    @(posedge clk); #1;
    // Squash while waiting in DONE
    res_ready = 1'b0;
    drive_op(2'b00, 6'h00, 5'd0, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    assertions++; if (res_valid !== 1'b0) begin failures++; $display("FAIL flush_done: got valid=%b expected 0", res_valid); end
    // Op presented during flush is not taken
    @(posedge clk); #1;
    alu_op = 2'b00; opa = 32'd9; opb = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      assertions++; if (res_valid !== 1'b0) begin failures++; $display("FAIL flush_noaccept[%0d]: got %b expected 0", i, res_valid); end
    end
    @(posedge clk); #1;
    // Reset during EXEC
    drive_op(2'b00, 6'h00, 5'd0, 32'd11, 32'd22, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; exp_count = '0; last_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      assertions++; if ({res_valid, res_data} !== {1'b0, 32'd0}) begin failures++; $display("FAIL rst_exec[%0d]: got valid=%b data=%h expected 0 0", i, res_valid, res_data); end
    end
`ifdef ALU_EXEC_PERF_EN
    assertions++; if (op_count !== 32'd0) begin failures++; $display("FAIL rst_exec_op_count: got %0d expected 0", op_count); end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_beq_hold();
    test_decode();
    test_back_to_back();
    test_flush();
    assertions++;
    if (sb.size() !== 0) begin failures++; $display("FAIL pending_ops: %0d results never delivered, expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
